paddle_square_object: RTL and testbench

// - Paddle position controller and screen-to-bitmap locator; drives the paddle bitmap renderer.
// - Moves the paddle left/right once per frame from the keys, with a slow-to-fast acceleration FSM.
// - Per pixel: registered offsetX/offsetY/InsideRectangle relative to the paddle top-left corner.

---
 rtl/paddle_square_object.sv | 146 ++++++++++++++
 tb/tb_paddle_square_object.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/paddle_square_object.sv
// Paddle position controller with slow-to-fast key acceleration and a registered pixel locator.
// Optional PADDLE_WRAP_EN: wrap around the screen edges instead of clamping.
//
//   state | meaning
//   IDLE  | no key (or frozen), paddle still, hold_cnt = 0
//   SLOW  | moving STEP_SLOW per frame, hold_cnt counts slow moves
//   FAST  | moving STEP_FAST per frame in the same direction
module paddle_square_object #(
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 16,
  parameter int SCREEN_WIDTH    = 640,
  parameter int INIT_X          = 288,
  parameter int FIXED_Y         = 440,
  parameter int STEP_SLOW       = 4,
  parameter int STEP_FAST       = 8,
  parameter int HOLD_FRAMES     = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        leftKey,
  input  logic        rightKey,
  input  logic        freeze,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);
  localparam logic [11:0] MAX_X12 = 12'(SCREEN_WIDTH - OBJECT_WIDTH_X);
  localparam logic [11:0] W12 = 12'(OBJECT_WIDTH_X);
  localparam logic [11:0] H12 = 12'(OBJECT_HEIGHT_Y);
  localparam logic [11:0] SLOW12 = 12'(STEP_SLOW);
  localparam logic [11:0] FAST12 = 12'(STEP_FAST);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_L, DIR_R} dir_t;

  state_t        state, state_nxt;
  dir_t          dir, last_dir, last_dir_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt, hold_inc;
  logic          move_en;
  logic [11:0]   step12, x12, x_sum, x_target;
  logic [10:0]   x_nxt;

  assign topLeftY = 11'(FIXED_Y);

  always_comb begin
    dir          = DIR_NONE;
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    last_dir_nxt = last_dir;
    move_en      = 1'b0;
    step12       = SLOW12;
    hold_inc     = hold_cnt + 1'b1;

    if (leftKey && !rightKey)      dir = DIR_L;
    else if (rightKey && !leftKey) dir = DIR_R;

    if (freeze || dir == DIR_NONE) begin
      state_nxt = IDLE;
      hold_nxt  = '0;
    end else begin
      move_en      = 1'b1;
      last_dir_nxt = dir;
      if (state == IDLE || dir != last_dir) begin
        hold_nxt  = HW'(1);
        state_nxt = (HOLD_FRAMES > 1) ? SLOW : FAST;
      end else if (state == SLOW) begin
        hold_nxt  = hold_inc;
        state_nxt = (hold_inc >= HOLD_MAX) ? FAST : SLOW;
      end else begin
        step12 = FAST12;
      end
    end
  end

  // 12-bit arithmetic so neither direction can overflow before clamping
  always_comb begin
    x12      = {1'b0, topLeftX};
    x_sum    = x12 + step12;
    x_target = x12;
    if (move_en && dir == DIR_L) begin
      if (x12 < step12) begin
`ifdef PADDLE_WRAP_EN
        x_target = (x12 == 12'd0) ? MAX_X12 : 12'd0;
`else
        x_target = 12'd0;
`endif
      end else begin
        x_target = x12 - step12;
      end
    end else if (move_en && dir == DIR_R) begin
      if (x_sum > MAX_X12) begin
`ifdef PADDLE_WRAP_EN
        x_target = (x12 == MAX_X12) ? 12'd0 : MAX_X12;
`else
        x_target = MAX_X12;
`endif
      end else begin
        x_target = x_sum;
      end
    end
    x_nxt = x_target[10:0];
  end

  logic [11:0] px12, py12, tlx12, tly12;
  logic        inside_c;

  always_comb begin
    px12  = {1'b0, pixelX};
    py12  = {1'b0, pixelY};
    tlx12 = {1'b0, topLeftX};
    tly12 = {1'b0, topLeftY};
    inside_c = (px12 >= tlx12) && (px12 < tlx12 + W12) &&
               (py12 >= tly12) && (py12 < tly12 + H12);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      topLeftX        <= 11'(INIT_X);
      state           <= IDLE;
      hold_cnt        <= '0;
      last_dir        <= DIR_NONE;
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= inside_c;
      offsetX         <= inside_c ? (pixelX - topLeftX) : 11'd0;
      offsetY         <= inside_c ? (pixelY - topLeftY) : 11'd0;
      if (startOfFrame) begin
        topLeftX <= x_nxt;
        state    <= state_nxt;
        hold_cnt <= hold_nxt;
        last_dir <= last_dir_nxt;
      end
    end
  end

endmodule

// File: tb/tb_paddle_square_object.sv
// Scoreboard bench for paddle_square_object: a run-length reference model predicts every cycle.
module tb_paddle_square_object;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        startOfFrame = 1'b0, leftKey = 1'b0, rightKey = 1'b0, freeze = 1'b0;
  logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
  logic        InsideRectangle;

  paddle_square_object dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .leftKey(leftKey), .rightKey(rightKey), .freeze(freeze),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .topLeftX(topLeftX), .topLeftY(topLeftY)
  );

  always #5 clk = ~clk;

`ifdef PADDLE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    int x;
    bit ins;
    int ox;
    int oy;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  // model: moves in one unbroken direction run counted; first 8 are slow, the rest fast
  int mx = 288, run = 0, pdir = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic cyc(input bit rst_n, input bit sof, input bit lk, input bit rk,
                     input bit frz, input int px, input int py);
    exp_t e;
    int d, step;
    @(negedge clk);
    resetN = rst_n; startOfFrame = sof; leftKey = lk; rightKey = rk; freeze = frz;
    pixelX = 11'(px); pixelY = 11'(py);
    if (!rst_n) begin
      mx = 288; run = 0; pdir = 0;
      e.ins = 0; e.ox = 0; e.oy = 0;
    end else begin
      e.ins = (px >= mx) && (px < mx + 64) && (py >= 440) && (py < 456);
      e.ox  = e.ins ? px - mx : 0;
      e.oy  = e.ins ? py - 440 : 0;
      if (sof) begin
        d = (lk && !rk) ? 1 : (rk && !lk) ? 2 : 0;
        if (frz || d == 0) run = 0;
        else begin
          run  = (d == pdir && run > 0) ? run + 1 : 1;
          pdir = d;
          step = (run <= 8) ? 4 : 8;
          if (d == 1) mx = (WRAP && mx == 0) ? 576 : ((mx < step) ? 0 : mx - step);
          else        mx = (WRAP && mx == 576) ? 0 : ((mx + step > 576) ? 576 : mx + step);
        end
      end
    end
    e.x = mx;
    q.push_back(e);
  endtask

  function automatic int rnd_px();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 799));
    return (mx < 4 ? 0 : mx - 4) + int'($urandom_range(0, 72));
  endfunction

  function automatic int rnd_py();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 599));
    return int'($urandom_range(436, 460));
  endfunction

  task automatic frame(input bit lk, input bit rk, input bit frz);
    cyc(1, 1, lk, rk, frz, rnd_px(), rnd_py());
    cyc(1, 0, lk, rk, frz, rnd_px(), rnd_py());
    cyc(1, 0, lk, rk, frz, rnd_px(), rnd_py());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("topLeftX", int'(topLeftX), e.x);
        check("topLeftY", int'(topLeftY), 440);
        check("InsideRectangle", int'(InsideRectangle), int'(e.ins));
        check("offsetX", int'(offsetX), e.ox);
        check("offsetY", int'(offsetY), e.oy);
      end
    end
  end

  initial begin : stimulus
    bit lk, rk, frz, rst;
    int guard;

    do_reset();
    settle();
    check("reset_x", int'(topLeftX), 288);
    check("reset_inside", int'(InsideRectangle), 0);

    cyc(1, 0, 0, 0, 0, 300, 445); settle();
    check("loc_a_in", int'(InsideRectangle), 1);
    check("loc_a_ox", int'(offsetX), 12);
    check("loc_a_oy", int'(offsetY), 5);
    cyc(1, 0, 0, 0, 0, 351, 455); settle();
    check("loc_b_ox", int'(offsetX), 63);
    check("loc_b_oy", int'(offsetY), 15);
    cyc(1, 0, 0, 0, 0, 352, 445); settle();
    check("loc_right_edge", int'(InsideRectangle), 0);
    cyc(1, 0, 0, 0, 0, 300, 456); settle();
    check("loc_bottom_edge", int'(InsideRectangle), 0);
    check("loc_bottom_ox", int'(offsetX), 0);

    for (int i = 0; i < 8; i++) frame(0, 1, 0);
    settle(); check("accel_8", int'(topLeftX), 320);
    frame(0, 1, 0); frame(0, 1, 0);
    settle(); check("accel_10", int'(topLeftX), 336);
    frame(0, 0, 0);
    settle(); check("release", int'(topLeftX), 336);
    frame(0, 1, 0);
    settle(); check("repress_slow", int'(topLeftX), 340);

    guard = 0;
    while (mx != 576 && guard < 200) begin frame(0, 1, 0); guard++; end
    settle(); check("right_edge", int'(topLeftX), 576);
    frame(0, 1, 0);
    settle(); check("right_beyond", int'(topLeftX), WRAP ? 0 : 576);

    guard = 0;
    while (mx != 0 && guard < 200) begin frame(1, 0, 0); guard++; end
    settle(); check("left_edge", int'(topLeftX), 0);
    frame(1, 0, 0);
    settle(); check("left_beyond", int'(topLeftX), WRAP ? 576 : 0);

    do_reset();
    frame(1, 1, 0);
    settle(); check("both_keys", int'(topLeftX), 288);
    frame(0, 1, 1);
    settle(); check("freeze", int'(topLeftX), 288);
    frame(0, 1, 0);
    settle(); check("after_freeze_slow", int'(topLeftX), 292);
    for (int i = 0; i < 10; i++) frame(0, 1, 0);
    do_reset();
    settle(); check("reset_in_fast", int'(topLeftX), 288);

    lk = 0; rk = 0; frz = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) lk = ~lk;
      if ($urandom_range(0, 29) == 0) rk = ~rk;
      frz = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cyc(!rst, $urandom_range(0, 3) == 0, lk, rk, frz, rnd_px(), rnd_py());
    end

    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
